wb_trace_fifo: RTL and testbench

Downstream debug consumer of the multicycle RISC-V core. Captures committed register-file writebacks (rd, data, PC) and exception events (cause flag), tags each with a sequence number, and buffers them in a circular FIFO. Entries drain through a valid/ready port to a debug host or testbench scoreboard. The core is never stalled: on overflow, events are dropped and counted.

---
 rtl/wb_trace_fifo.sv | 117 +++++++++++
 tb/tb_wb_trace_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - commit/exception trace capture FIFO with sequence tags and drop counting
// Never back-pressures the core: events that cannot be stored are counted in drop_count.
module wb_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int SEQ_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic [63:0]              wb_data,
  input  logic [63:0]              wb_pc,
  input  logic                     exc_valid,
  input  logic                     exc_cause,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_kind,
  output logic [4:0]               out_rd,
  output logic [63:0]              out_data,
  output logic [63:0]              out_pc,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic             mem_kind [DEPTH];
  logic [4:0]       mem_rd   [DEPTH];
  logic [63:0]      mem_data [DEPTH];
  logic [63:0]      mem_pc   [DEPTH];
  logic [SEQ_W-1:0] mem_seq  [DEPTH];

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [SEQ_W-1:0] seq_ctr;

  logic        wb_evt;
  logic        exc_evt;
  logic        push_req;
  logic        empty;
  logic        full;
  logic        pop;
  logic        accept;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  logic        new_kind;
  logic [4:0]  new_rd;
  logic [63:0] new_data;

  assign wb_evt   = wb_valid && (wb_rd != 5'd0);
  assign exc_evt  = exc_valid;
  assign push_req = wb_evt || exc_evt;

  assign empty  = (rd_ptr == wr_ptr);
  assign full   = (rd_ptr[AW] != wr_ptr[AW]) && (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);
  assign pop    = !empty && out_ready;
  assign accept = push_req && (!full || pop);

  // A cycle with both events and no room loses two events.
  assign drop_inc = {1'b0, push_req && !accept} + {1'b0, wb_evt && exc_evt};
  assign drop_sum = {1'b0, drop_count} + {15'b0, drop_inc};

  assign new_kind = exc_evt;
  assign new_rd   = exc_evt ? 5'd0 : wb_rd;
  assign new_data = exc_evt ? {63'b0, exc_cause} : wb_data;

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_kind[wr_ptr[AW-1:0]] <= new_kind;
      mem_rd[wr_ptr[AW-1:0]]   <= new_rd;
      mem_data[wr_ptr[AW-1:0]] <= new_data;
      mem_pc[wr_ptr[AW-1:0]]   <= wb_pc;
      mem_seq[wr_ptr[AW-1:0]]  <= seq_ctr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      seq_ctr    <= '0;
      drop_count <= '0;
    end else begin
      if (accept) begin
        wr_ptr  <= wr_ptr + PW'(1);
        seq_ctr <= seq_ctr + SEQ_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // Gating by empty keeps the head fields at zero out of reset without clearing storage.
  always_comb begin
    out_valid = !empty;
    out_kind  = 1'b0;
    out_rd    = 5'd0;
    out_data  = 64'd0;
    out_pc    = 64'd0;
    out_seq   = '0;
    if (!empty) begin
      out_kind = mem_kind[rd_ptr[AW-1:0]];
      out_rd   = mem_rd[rd_ptr[AW-1:0]];
      out_data = mem_data[rd_ptr[AW-1:0]];
      out_pc   = mem_pc[rd_ptr[AW-1:0]];
      out_seq  = mem_seq[rd_ptr[AW-1:0]];
    end
  end

  assign level = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb/tb_wb_trace_fifo.sv - directed self-checking bench for wb_trace_fifo
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_wb_trace_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [63:0] wb_pc;
  logic        exc_valid;
  logic        exc_cause;
  logic        out_valid;
  logic        out_ready;
  logic        out_kind;
  logic [4:0]  out_rd;
  logic [63:0] out_data;
  logic [63:0] out_pc;
  logic [15:0] out_seq;
  logic [3:0]  level;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  wb_trace_fifo #(.DEPTH(8), .SEQ_W(16)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
    .exc_valid(exc_valid), .exc_cause(exc_cause),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_rd(out_rd), .out_data(out_data), .out_pc(out_pc), .out_seq(out_seq),
    .level(level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid  = 1'b0;
    wb_rd     = 5'd0;
    wb_data   = 64'd0;
    wb_pc     = 64'd0;
    exc_valid = 1'b0;
    exc_cause = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [63:0] data, input logic [63:0] pc);
    wb_valid = 1'b1;
    wb_rd    = rd;
    wb_data  = data;
    wb_pc    = pc;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_kind !== 1'b0) begin n_err++; $display("FAIL rst_kind got %0b want 0", out_kind); end
    n_cmp++; if (out_rd !== 5'd0) begin n_err++; $display("FAIL rst_rd got %0d want 0", out_rd); end
    n_cmp++; if (out_data !== 64'd0) begin n_err++; $display("FAIL rst_data got %h want 0", out_data); end
    n_cmp++; if (out_pc !== 64'd0) begin n_err++; $display("FAIL rst_pc got %h want 0", out_pc); end
    n_cmp++; if (out_seq !== 16'd0) begin n_err++; $display("FAIL rst_seq got %0d want 0", out_seq); end
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", level); end
    n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL rst_drop got %0d want 0", drop_count); end
  endtask

  task automatic test_single_wb();
    push_wb(5'd5, 64'hDEAD_BEEF, 64'h10);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_kind !== 1'b0) begin n_err++; $display("FAIL single_kind got %0b want 0", out_kind); end
    n_cmp++; if (out_rd !== 5'd5) begin n_err++; $display("FAIL single_rd got %0d want 5", out_rd); end
    n_cmp++; if (out_data !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL single_data got %h want deadbeef", out_data); end
    n_cmp++; if (out_pc !== 64'h10) begin n_err++; $display("FAIL single_pc got %h want 10", out_pc); end
    n_cmp++; if (out_seq !== 16'd0) begin n_err++; $display("FAIL single_seq got %0d want 0", out_seq); end
    n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL single_level got %0d want 1", level); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid got %0b want 0", out_valid); end
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL single_pop_level got %0d want 0", level); end
  endtask

  task automatic test_x0_collision();
    push_wb(5'd0, 64'h1234, 64'h20);
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL x0_level got %0d want 0", level); end
    n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL x0_drop got %0d want 0", drop_count); end
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h5555; wb_pc = 64'h24;
    exc_valid = 1'b1; exc_cause = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL coll_level got %0d want 1", level); end
    n_cmp++; if (out_kind !== 1'b1) begin n_err++; $display("FAIL coll_kind got %0b want 1", out_kind); end
    n_cmp++; if (out_rd !== 5'd0) begin n_err++; $display("FAIL coll_rd got %0d want 0", out_rd); end
    n_cmp++; if (out_data !== 64'd1) begin n_err++; $display("FAIL coll_data got %h want 1", out_data); end
    n_cmp++; if (out_pc !== 64'h24) begin n_err++; $display("FAIL coll_pc got %h want 24", out_pc); end
    n_cmp++; if (out_seq !== 16'd1) begin n_err++; $display("FAIL coll_seq got %0d want 1", out_seq); end
    n_cmp++; if (drop_count !== 16'd1) begin n_err++; $display("FAIL coll_drop got %0d want 1", drop_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) push_wb(5'(i + 1), 64'(100 + i), 64'(4 * i));
    n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL ovf_level got %0d want 8", level); end
    n_cmp++; if (drop_count !== 16'd2) begin n_err++; $display("FAIL ovf_drop got %0d want 2", drop_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (out_seq !== 16'(i)) begin n_err++; $display("FAIL ovf_seq[%0d] got %0d want %0d", i, out_seq, i); end
      n_cmp++; if (out_data !== 64'(100 + i)) begin n_err++; $display("FAIL ovf_data[%0d] got %0d want %0d", i, out_data, 100 + i); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) push_wb(5'(i + 1), 64'(200 + i), 64'(8 * i));
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h999; wb_pc = 64'h90;
    out_ready = 1'b1;
    tick();
    idle_inputs();
    out_ready = 1'b0;
    n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL fpp_level got %0d want 8", level); end
    n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL fpp_drop got %0d want 0", drop_count); end
    n_cmp++; if (out_seq !== 16'd1) begin n_err++; $display("FAIL fpp_head got %0d want 1", out_seq); end
    out_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      n_cmp++; if (out_seq !== 16'(i)) begin n_err++; $display("FAIL fpp_seq[%0d] got %0d want %0d", i, out_seq, i); end
      if (i == 8) begin
        n_cmp++; if (out_data !== 64'h999) begin n_err++; $display("FAIL fpp_newdata got %h want 999", out_data); end
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL fpp_drained got %0d want 0", level); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_wb(5'd7, 64'hAAAA, 64'h70);
    for (int i = 0; i < 5; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(8 + i); wb_data = 64'(16'hB000 + i); wb_pc = 64'(8'h80 + 4 * i);
      tick();
      idle_inputs();
      n_cmp++;
      if (out_rd !== 5'd7 || out_data !== 64'hAAAA || out_pc !== 64'h70 || out_seq !== 16'd0 || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold[%0d] got rd=%0d data=%h pc=%h seq=%0d want rd=7 data=aaaa pc=70 seq=0", i, out_rd, out_data, out_pc, out_seq);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (out_seq !== 16'(i)) begin n_err++; $display("FAIL b2b_seq[%0d] got %0d want %0d", i, out_seq, i); end
      n_cmp++; if (level !== 4'(6 - i)) begin n_err++; $display("FAIL b2b_level[%0d] got %0d want %0d", i, level, 6 - i); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_seq_wrap_reset();
    do_reset();
    out_ready = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd1;
    for (int i = 0; i < 65535; i++) begin
      wb_data = 64'(i);
      tick();
    end
    idle_inputs();
    tick();
    out_ready = 1'b0;
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL wrap_level got %0d want 0", level); end
    push_wb(5'd2, 64'h1, 64'h100);
    push_wb(5'd3, 64'h2, 64'h104);
    n_cmp++; if (out_seq !== 16'hFFFF) begin n_err++; $display("FAIL wrap_seq_ffff got %h want ffff", out_seq); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_seq !== 16'h0000) begin n_err++; $display("FAIL wrap_seq_0 got %h want 0000", out_seq); end
    n_cmp++; if (out_data !== 64'h2) begin n_err++; $display("FAIL wrap_data got %h want 2", out_data); end
    wb_valid = 1'b1; wb_rd = 5'd4; exc_valid = 1'b1; exc_cause = 1'b0;
    tick();
    idle_inputs();
    n_cmp++; if (drop_count !== 16'd1) begin n_err++; $display("FAIL pre_arst_drop got %0d want 1", drop_count); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %0b want 0", out_valid); end
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL arst_level got %0d want 0", level); end
    n_cmp++; if (drop_count !== 16'd0) begin n_err++; $display("FAIL arst_drop got %0d want 0", drop_count); end
    n_cmp++; if (out_seq !== 16'd0 || out_data !== 64'd0 || out_rd !== 5'd0) begin
      n_err++; $display("FAIL arst_head got seq=%0d data=%h rd=%0d want 0", out_seq, out_data, out_rd);
    end
    #1;
    reset = 1'b0;
    push_wb(5'd6, 64'h66, 64'h200);
    n_cmp++; if (out_seq !== 16'd0) begin n_err++; $display("FAIL post_arst_seq got %0d want 0", out_seq); end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single_wb();
    test_x0_collision();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_seq_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
